vme_system_controller: RTL and testbench

- VME slot-1 system controller. Sits directly downstream of the board's bus-request logic.
- Consumes the BR0..BR3 request lines and the BBSY line, and drives the BG0..BG3 daisy-chain heads that return as the requester's bus_grant_in.
- Also provides the global bus timer: when a data strobe goes unanswered it asserts BERR so that the requester's data-transfer logic terminates the cycle.
- All VME control signals are active-low (ACTIVE=0, INACTIVE=1). Open-collector drive is done at the top level.

---
 rtl/vme_defs.sv | 40 ++++
 rtl/vme_bus_timer.sv | 52 +++++
 rtl/vme_sync2.sv | 23 ++
 rtl/vme_system_controller.sv | 113 +++++++++++
 tb/tb_vme_system_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vme_defs.sv
// Shared VME controller definitions: signal polarity, arbiter state encoding,
// default timeouts and the level-selection helper used by the arbiter.
package vme_defs;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam int DEF_GRANT_TIMEOUT = 32;
  localparam int DEF_BUS_TIMEOUT   = 256;
  localparam int DEF_CNT_W         = 9;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_OWNED = 2'd2
  } arb_state_t;

  // Round robin searches ptr-1, ptr-2, ... with wrap; the nearest candidate is
  // visited last so it wins.
  function automatic logic [1:0] pick_level(input logic [3:0] br_b,
                                            input logic       rr,
                                            input logic [1:0] ptr);
    logic [1:0] lvl;
    logic [1:0] cand;
    lvl  = 2'd0;
    cand = 2'd0;
    if (rr) begin
      for (int i = 3; i >= 0; i--) begin
        cand = ptr - 2'(i + 1);
        if (br_b[cand] == ACTIVE) lvl = cand;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (br_b[i] == ACTIVE) lvl = 2'(i);
      end
    end
    return lvl;
  endfunction

endpackage

// File: rtl/vme_bus_timer.sv
// Global bus timer: forces BERR when a data strobe stays unanswered too long,
// and holds it until the strobe is withdrawn.
module vme_bus_timer
  import vme_defs::*;
#(
  parameter int BUS_TIMEOUT = DEF_BUS_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ds_s,
  input  logic       dtack_s,
  input  logic       berr_in_s,
  output logic       berr_out,
  output logic       timeout_event
);

  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIMIT_SAT  = CNT_W'(BUS_TIMEOUT);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  // A DTACK or foreign BERR seen on the limit cycle disarms, so it wins the race.
  assign armed = (ds_s != 2'b11) && (dtack_s == INACTIVE) &&
                 (berr_in_s == INACTIVE) && (berr_out == INACTIVE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      berr_out      <= INACTIVE;
      timeout_event <= 1'b0;
    end else begin
      timeout_event <= 1'b0;
      if (berr_out == ACTIVE) begin
        if (ds_s == 2'b11) begin
          berr_out <= INACTIVE;
          cnt      <= '0;
        end
      end else if (armed) begin
        if (cnt == LIMIT_LAST) begin
          berr_out      <= ACTIVE;
          timeout_event <= 1'b1;
        end
        if (cnt != LIMIT_SAT) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/vme_sync2.sv
// Generic two-flop synchronizer for one active-low asynchronous line; idles inactive.
module vme_sync2
  import vme_defs::*;
(
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= INACTIVE;
      q    <= INACTIVE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vme_system_controller.sv
// VME slot-1 system controller: bus arbiter driving the BG daisy-chain heads
// plus the global bus timer.
//
// state     | meaning
// ARB_IDLE  | no grant out; arbitrate when a request is seen and BBSY is free
// ARB_GRANT | one BG low, waiting for the requester to take BBSY
// ARB_OWNED | bus taken, all BG high until BBSY is released
module vme_system_controller
  import vme_defs::*;
#(
  parameter bit ARB_ROUND_ROBIN = 1'b0,
  parameter int GRANT_TIMEOUT   = DEF_GRANT_TIMEOUT,
  parameter int BUS_TIMEOUT     = DEF_BUS_TIMEOUT,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] vme_bus_request,
  input  logic       vme_bus_busy,
  output logic [3:0] vme_bus_grant,
  input  logic [1:0] vme_ds,
  input  logic       vme_dtack,
  input  logic       vme_berr_in,
  output logic       vme_berr_out,
  output logic [1:0] granted_level,
  output logic       timeout_event
);

  localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

  logic [8:0] async_in;
  logic [8:0] sync_out;
  logic [3:0] br_s;
  logic       bbsy_s;
  logic [1:0] ds_s;
  logic       dtack_s;
  logic       berr_in_s;

  assign async_in = {vme_bus_request, vme_bus_busy, vme_ds, vme_dtack, vme_berr_in};
  assign {br_s, bbsy_s, ds_s, dtack_s, berr_in_s} = sync_out;

  for (genvar i = 0; i < 9; i++) begin : g_sync
    vme_sync2 u_sync (
      .clock (clock),
      .reset (reset),
      .d     (async_in[i]),
      .q     (sync_out[i])
    );
  end

  arb_state_t       state;
  logic [CNT_W-1:0] arb_cnt;
  logic [1:0]       rr_ptr;
  logic [1:0]       sel_level;
  logic             any_req;

  assign any_req   = (br_s != 4'b1111);
  assign sel_level = pick_level(br_s, ARB_ROUND_ROBIN, rr_ptr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ARB_IDLE;
      arb_cnt       <= '0;
      rr_ptr        <= '0;
      vme_bus_grant <= 4'b1111;
      granted_level <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req && (bbsy_s == INACTIVE)) begin
            vme_bus_grant <= ~(4'b0001 << sel_level);
            granted_level <= sel_level;
            arb_cnt       <= '0;
            state         <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (bbsy_s == ACTIVE) begin
            vme_bus_grant <= 4'b1111;
            state         <= ARB_OWNED;
            if (ARB_ROUND_ROBIN) rr_ptr <= granted_level;
          end else if (arb_cnt == GRANT_LAST) begin
            vme_bus_grant <= 4'b1111;
            state         <= ARB_IDLE;
          end else begin
            arb_cnt <= arb_cnt + CNT_W'(1);
          end
        end
        ARB_OWNED: begin
          if (bbsy_s == INACTIVE) state <= ARB_IDLE;
        end
        default: begin
          vme_bus_grant <= 4'b1111;
          state         <= ARB_IDLE;
        end
      endcase
    end
  end

  vme_bus_timer #(
    .BUS_TIMEOUT (BUS_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_bus_timer (
    .clock         (clock),
    .reset         (reset),
    .ds_s          (ds_s),
    .dtack_s       (dtack_s),
    .berr_in_s     (berr_in_s),
    .berr_out      (vme_berr_out),
    .timeout_event (timeout_event)
  );

endmodule

// File: tb/tb_vme_system_controller.sv
// Directed bench for the VME system controller: fixed-priority and round-robin
// instances, grant timeout, bus timer, DTACK race and asynchronous reset.
module tb_vme_system_controller;

  logic       clock;
  logic       reset;
  logic [3:0] br, br_rr;
  logic       bbsy, bbsy_rr;
  logic [1:0] ds;
  logic       dtack, berr_in;
  logic [3:0] bg_fx, bg_rr;
  logic       berr_fx, berr_rr;
  logic [1:0] gl_fx, gl_rr;
  logic       te_fx, te_rr;

  int total = 0;
  int bad   = 0;

  vme_system_controller #(.ARB_ROUND_ROBIN(1'b0)) dut_fx (
    .clock (clock), .reset (reset),
    .vme_bus_request (br), .vme_bus_busy (bbsy), .vme_bus_grant (bg_fx),
    .vme_ds (ds), .vme_dtack (dtack), .vme_berr_in (berr_in),
    .vme_berr_out (berr_fx), .granted_level (gl_fx), .timeout_event (te_fx)
  );

  vme_system_controller #(.ARB_ROUND_ROBIN(1'b1)) dut_rr (
    .clock (clock), .reset (reset),
    .vme_bus_request (br_rr), .vme_bus_busy (bbsy_rr), .vme_bus_grant (bg_rr),
    .vme_ds (ds), .vme_dtack (dtack), .vme_berr_in (berr_in),
    .vme_berr_out (berr_rr), .granted_level (gl_rr), .timeout_event (te_rr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic bg_legal(input logic [3:0] g);
    return (g == 4'b1111) || ($countones(~g) == 1);
  endfunction

  always @(negedge clock) begin
    check("bg_exclusive_fx", 32'(bg_legal(bg_fx)), 32'd1);
    check("bg_exclusive_rr", 32'(bg_legal(bg_rr)), 32'd1);
  end

  task automatic wait_rr(input logic want_grant, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ((bg_rr != 4'b1111) == want_grant) begin
        ok = 1'b1;
        return;
      end
      tick(1);
    end
  endtask

  initial begin
    logic [3:0] rr_exp [4];
    logic       ok;
    rr_exp[0] = 4'b0111; rr_exp[1] = 4'b1101;
    rr_exp[2] = 4'b0111; rr_exp[3] = 4'b1101;

    reset = 1'b0; br = 4'b1111; br_rr = 4'b1111; bbsy = 1'b1; bbsy_rr = 1'b1;
    ds = 2'b11; dtack = 1'b1; berr_in = 1'b1;
    tick(2);
    check("rst_bg", 32'(bg_fx), 32'hF);
    check("rst_berr", 32'(berr_fx), 32'd1);
    check("rst_level", 32'(gl_fx), 32'd0);
    check("rst_event", 32'(te_fx), 32'd0);
    reset = 1'b1;
    tick(2);

    // bus held by an earlier owner: no grant while BBSY is low
    bbsy = 1'b0; br = 4'b1110;
    tick(6);
    check("idle_bbsy_held", 32'(bg_fx), 32'hF);
    br = 4'b1111; bbsy = 1'b1;
    tick(3);

    // single request on BR1
    br = 4'b1101;
    tick(2);
    check("req_latency", 32'(bg_fx), 32'hF);
    tick(1);
    check("single_bg1", 32'(bg_fx), 32'hD);
    check("single_level", 32'(gl_fx), 32'd1);
    bbsy = 1'b0;
    tick(2);
    check("bg_held_until_bbsy", 32'(bg_fx), 32'hD);
    tick(1);
    check("bg_release_owned", 32'(bg_fx), 32'hF);
    bbsy = 1'b1; br = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("no_regrant", 32'(bg_fx), 32'hF);
    end

    // fixed priority: BR2 beats BR0, then BR0 after the BR2 tenure
    br = 4'b1010;
    tick(3);
    check("prio_bg2", 32'(bg_fx), 32'hB);
    check("prio_level2", 32'(gl_fx), 32'd2);
    bbsy = 1'b0;
    tick(3);
    check("prio_owned", 32'(bg_fx), 32'hF);
    br = 4'b1110; bbsy = 1'b1;
    tick(3);
    check("prio_idle_gap", 32'(bg_fx), 32'hF);
    tick(1);
    check("prio_bg0", 32'(bg_fx), 32'hE);
    check("prio_level0", 32'(gl_fx), 32'd0);
    bbsy = 1'b0;
    tick(3);
    check("prio_bg0_owned", 32'(bg_fx), 32'hF);
    br = 4'b1111; bbsy = 1'b1;
    tick(4);

    // grant timeout: BG2 low for exactly 32 cycles, then reissued
    br = 4'b1011;
    tick(3);
    check("gto_start", 32'(bg_fx), 32'hB);
    tick(31);
    check("gto_hold_last", 32'(bg_fx), 32'hB);
    tick(1);
    check("gto_release", 32'(bg_fx), 32'hF);
    tick(1);
    check("gto_reissue", 32'(bg_fx), 32'hB);
    br = 4'b1111;
    tick(40);
    check("gto_quiet", 32'(bg_fx), 32'hF);

    // round robin: BR3 and BR1 held across four tenures
    br_rr = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_rr(1'b1, ok);
      check("rr_grant_seen", 32'(ok), 32'd1);
      check("rr_grant_order", 32'(bg_rr), 32'(rr_exp[k]));
      check("rr_level", 32'(gl_rr), (k % 2 == 0) ? 32'd3 : 32'd1);
      bbsy_rr = 1'b0;
      wait_rr(1'b0, ok);
      check("rr_release_seen", 32'(ok), 32'd1);
      bbsy_rr = 1'b1;
    end
    br_rr = 4'b1111;
    tick(6);

    // bus timeout: BERR 258 cycles after the DS edge, single event pulse
    ds = 2'b00;
    tick(257);
    check("bto_before", 32'(berr_fx), 32'd1);
    check("bto_event_before", 32'(te_fx), 32'd0);
    tick(1);
    check("bto_berr", 32'(berr_fx), 32'd0);
    check("bto_event", 32'(te_fx), 32'd1);
    tick(1);
    check("bto_event_single", 32'(te_fx), 32'd0);
    check("bto_berr_held", 32'(berr_fx), 32'd0);
    ds = 2'b11;
    tick(2);
    check("bto_berr_until_ds", 32'(berr_fx), 32'd0);
    tick(1);
    check("bto_berr_release", 32'(berr_fx), 32'd1);
    tick(3);

    // DTACK synchronized on the limit cycle wins
    ds = 2'b00;
    tick(255);
    dtack = 1'b0;
    tick(3);
    check("race_no_berr", 32'(berr_fx), 32'd1);
    check("race_no_event", 32'(te_fx), 32'd0);
    ds = 2'b11; dtack = 1'b1;
    tick(4);

    // a short strobe must not leave a partial count behind
    ds = 2'b00;
    tick(100);
    ds = 2'b11;
    tick(5);
    ds = 2'b00;
    tick(257);
    check("restart_before", 32'(berr_fx), 32'd1);
    tick(1);
    check("restart_berr", 32'(berr_fx), 32'd0);
    check("restart_event", 32'(te_fx), 32'd1);
    ds = 2'b11;
    tick(4);
    check("restart_release", 32'(berr_fx), 32'd1);

    // foreign BERR on the bus keeps the timer disarmed
    berr_in = 1'b0; ds = 2'b00;
    tick(300);
    check("berr_in_disarm", 32'(berr_fx), 32'd1);
    ds = 2'b11; berr_in = 1'b1;
    tick(4);

    // asynchronous reset while in GRANT
    br = 4'b0111;
    tick(3);
    check("rst_pre_grant", 32'(bg_fx), 32'h7);
    #2 reset = 1'b0;
    #1;
    check("async_rst_bg", 32'(bg_fx), 32'hF);
    check("async_rst_level", 32'(gl_fx), 32'd0);
    tick(2);
    reset = 1'b1; br = 4'b1111;
    tick(4);
    check("post_rst_idle", 32'(bg_fx), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
